id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode/register-file read and execute in the pipelined processor. It captures the three register-file read operands, the operand addresses, the destination address, the immediate and the decoded control word on each advancing clock edge. It supports hold (stall) and bubble insertion (flush). It bypasses the same-cycle writeback value into any operand the register file has not yet updated, both at capture time and while the stage is held.

## Interface
Parameters:
- DATA_W, 32, operand/immediate/writeback data width
- ADDR_W, 4, register address width (16 registers)
- CTRL_W, 8, decoded control word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents a valid instruction
- RS1, RS2, RS3  in  ADDR_W each  source addresses driven to the register file
- RD1, RD2, RD3  in  DATA_W each  register-file read data for RS1..RS3
- RD  in  ADDR_W  destination register address
- ctrl  in  CTRL_W  decoded control word
- imm  in  DATA_W  extended immediate
- stall  in  1  hold the stage; execute is not accepting
- flush  in  1  insert a bubble
- wb_en  in  1  writeback writes the register file this cycle (the register file wr_enable)
- wb_addr  in  ADDR_W  writeback destination (the register file RD)
- wb_data  in  DATA_W  writeback data (the register file WD)
- in_ready  out  1  equals ~stall, combinational
- ex_valid  out  1  stage holds a valid instruction
- ex_op1, ex_op2, ex_op3  out  DATA_W each  bypass-corrected operands
- ex_rs1, ex_rs2, ex_rs3  out  ADDR_W each  captured source addresses, used by forwarding
- ex_rd  out  ADDR_W  captured destination
- ex_ctrl  out  CTRL_W  captured control; all-zero means no-op
- ex_imm  out  DATA_W  captured immediate
- stall_count, bubble_count  out  16 each  performance counters (see Configuration)

## Operation
- Every output is registered except in_ready.
- Edge priority: rst > flush > stall > advance.
- rst: every registered output goes to 0, including ex_valid, both counters and all data and address fields.
- flush: ex_valid and ex_ctrl go to 0. All other fields go to 0. Flush applies even when stall is high.
- stall (no flush): all fields hold. Bypass still applies. For each N, if wb_en and wb_addr == ex_rsN, then ex_opN <= wb_data. No other field changes.
- advance: ex_valid <= in_valid. ex_rsN, ex_rd, ex_imm are captured unconditionally. ex_ctrl <= in_valid ? ctrl : 0.
  - Operand capture: ex_opN <= (wb_en && wb_addr == RSN) ? wb_data : RDN.
- Bypass rules:
  - Register 0 is not special; it is bypassed like any other register.
  - Any number of operands may match the same wb_addr; all take wb_data.
  - wb_en low means no bypass, regardless of address.
- Widths: address compares are full ADDR_W. No arithmetic on data.

## Timing
- Latency: 1 cycle from capture edge to ex_* outputs.
- Throughput: one instruction per cycle while stall is low.
- in_ready follows stall in the same cycle. Decode must hold its inputs while in_ready is low.
- The register file writes at the same edge the stage captures. Its read data is therefore stale for a same-cycle write, which the bypass corrects.
- Reset asserted mid-stall or mid-flush: reset wins at that edge. Outputs go to 0 on the following cycle.
- Stall released: the next edge captures new inputs. Held, bypass-updated operands are discarded only by that capture.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - stall_count increments on each non-reset edge with stall=1 and flush=0.
  - bubble_count increments on each non-reset edge with flush=1, or with an advance where in_valid=0.
  - Both counters saturate at 16'hFFFF and clear on rst.
- IDEX_PERF_CNT_EN undefined: no counter flops are built. stall_count and bubble_count are tied to 16'd0. The port list is unchanged.

## Test plan
- Reset: rst=1 for 2 cycles with nonzero inputs -> all outputs 0; after release, in_valid=1, RS1=3, RD1=99, ctrl=8'h05 -> next cycle ex_valid=1, ex_op1=99, ex_rs1=3, ex_ctrl=8'h05.
- Capture bypass: RS1=5, RD1=0, wb_en=1, wb_addr=5, wb_data=255 -> ex_op1=255. Repeat with wb_en=0 -> ex_op1=0.
- Multi-operand bypass: RS1=RS2=RS3=3, RDx=7, wb_en=1, wb_addr=3, wb_data=2 -> ex_op1=ex_op2=ex_op3=2.
- Stall with bypass: capture ex_rs2=4, ex_op2=10. Then stall=1 for 3 cycles with wb_en=1, wb_addr=4, wb_data=50 on the 2nd cycle -> in_ready=0, other fields constant, ex_op2 becomes 50 after that edge. With IDEX_PERF_CNT_EN, stall_count=3.
- Flush over stall: stall=1, flush=1 -> ex_valid=0, ex_ctrl=0. With IDEX_PERF_CNT_EN, bubble_count=1 and stall_count unchanged.
- Counter saturation (IDEX_PERF_CNT_EN defined): stall held 65540 cycles -> stall_count=16'hFFFF. Without the macro, stall_count=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Pipeline register between decode/register-file read and execute.
//   It captures the three operands, their source addresses, the destination,
//   the immediate and the control word whenever the stage advances. The stage
//   can be held (stall) or cleared to a bubble (flush).
//   The register file writes on the same edge as this stage captures, so its
//   read data is stale for a same-cycle write. A writeback bypass corrects the
//   operands at capture time and keeps correcting them while the stage is held.
//
//   Optional build macro: IDEX_PERF_CNT_EN
//     Defined:   stall/bubble performance counters are built (16-bit, saturating).
//     Undefined: no counter flops are built, and both counter ports read 0.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, RS1..3, RD1..3,    decode-side instruction fields and the
//   RD, ctrl, imm                register-file read data
//   stall, flush                 hold the stage / insert a bubble
//   wb_en, wb_addr, wb_data      register-file write port, used for bypass
//   in_ready                     ~stall (combinational)
//   ex_valid, ex_op1..3,         registered execute-side fields
//   ex_rs1..3, ex_rd, ex_ctrl,
//   ex_imm
//   stall_count, bubble_count    performance counters
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic [ADDR_W-1:0] RS3,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic [DATA_W-1:0] RD3,
  input  logic [ADDR_W-1:0] RD,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] imm,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              in_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_op3,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [ADDR_W-1:0] ex_rs3,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_imm,
  output logic [15:0]       stall_count,
  output logic [15:0]       bubble_count
);

  logic                        valid_q, valid_d;
  logic [2:0][DATA_W-1:0]      op_q, op_d;
  logic [2:0][ADDR_W-1:0]      rs_q, rs_d;
  logic [ADDR_W-1:0]           rd_q, rd_d;
  logic [CTRL_W-1:0]           ctrl_q, ctrl_d;
  logic [DATA_W-1:0]           imm_q, imm_d;

  logic [2:0][ADDR_W-1:0]      rs_in;
  logic [2:0][DATA_W-1:0]      rdata_in;

  assign rs_in    = {RS3, RS2, RS1};
  assign rdata_in = {RD3, RD2, RD1};
  assign in_ready = ~stall;

  always_comb begin
    // Default is a hold with the held operands still tracking writeback.
    valid_d = valid_q;
    rs_d    = rs_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    for (int n = 0; n < 3; n++) begin
      op_d[n] = (wb_en && (wb_addr == rs_q[n])) ? wb_data : op_q[n];
    end

    if (flush) begin
      valid_d = 1'b0;
      op_d    = '0;
      rs_d    = '0;
      rd_d    = '0;
      ctrl_d  = '0;
      imm_d   = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      rs_d    = rs_in;
      rd_d    = RD;
      imm_d   = imm;
      ctrl_d  = in_valid ? ctrl : '0;
      for (int n = 0; n < 3; n++) begin
        op_d[n] = (wb_en && (wb_addr == rs_in[n])) ? wb_data : rdata_in[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_op1   = op_q[0];
  assign ex_op2   = op_q[1];
  assign ex_op3   = op_q[2];
  assign ex_rs1   = rs_q[0];
  assign ex_rs2   = rs_q[1];
  assign ex_rs3   = rs_q[2];
  assign ex_rd    = rd_q;
  assign ex_ctrl  = ctrl_q;
  assign ex_imm   = imm_q;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        stall_inc, bubble_inc;

  // A flush always counts as a bubble, even when stall is also high.
  assign stall_inc  = stall & ~flush;
  assign bubble_inc = flush | (~stall & ~in_valid);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_count  = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  assign stall_count  = 16'd0;
  assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 8;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic              rst;
    logic              in_valid;
    logic [2:0][AW-1:0] rs;
    logic [2:0][DW-1:0] rdat;
    logic [AW-1:0]     rd;
    logic [CW-1:0]     ctrl;
    logic [DW-1:0]     imm;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
  } in_t;

  typedef struct packed {
    logic              valid;
    logic [2:0][DW-1:0] op;
    logic [2:0][AW-1:0] rs;
    logic [AW-1:0]     rd;
    logic [CW-1:0]     ctrl;
    logic [DW-1:0]     imm;
    int unsigned       sc;
    int unsigned       bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, stall, flush, wb_en;
  logic [AW-1:0] RS1, RS2, RS3, RD, wb_addr;
  logic [DW-1:0] RD1, RD2, RD3, imm, wb_data;
  logic [CW-1:0] ctrl;
  logic in_ready, ex_valid;
  logic [DW-1:0] ex_op1, ex_op2, ex_op3, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rs3, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [15:0] stall_count, bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .RS1(RS1), .RS2(RS2), .RS3(RS3), .RD1(RD1), .RD2(RD2), .RD3(RD3),
    .RD(RD), .ctrl(ctrl), .imm(imm), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .in_ready(in_ready), .ex_valid(ex_valid),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs3(ex_rs3),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t model;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Reference: the stage is a box holding one instruction. Reset empties it,
  // flush empties it, stall keeps it (operands refreshed from writeback), and
  // otherwise the box is refilled from decode.
  function automatic exp_t next_state(input exp_t s, input in_t i);
    exp_t n;
    if (i.rst) return '0;
    n = s;
    if (i.flush) begin
      n    = '0;
      n.sc = s.sc;
      n.bc = PERF ? ((s.bc < 65535) ? s.bc + 1 : 65535) : 0;
    end else if (i.stall) begin
      for (int k = 0; k < 3; k++)
        if (i.wb_en && i.wb_addr == s.rs[k]) n.op[k] = i.wb_data;
      n.sc = PERF ? ((s.sc < 65535) ? s.sc + 1 : 65535) : 0;
    end else begin
      n.valid = i.in_valid;
      n.rs    = i.rs;
      n.rd    = i.rd;
      n.imm   = i.imm;
      n.ctrl  = i.in_valid ? i.ctrl : '0;
      for (int k = 0; k < 3; k++)
        n.op[k] = (i.wb_en && i.wb_addr == i.rs[k]) ? i.wb_data : i.rdat[k];
      if (!i.in_valid) n.bc = PERF ? ((s.bc < 65535) ? s.bc + 1 : 65535) : 0;
    end
    return n;
  endfunction

  // Drive one cycle of inputs, check in_ready, predict the post-edge state.
  task automatic drive(input in_t i);
    @(negedge clk);
    rst = i.rst; in_valid = i.in_valid;
    RS1 = i.rs[0]; RS2 = i.rs[1]; RS3 = i.rs[2];
    RD1 = i.rdat[0]; RD2 = i.rdat[1]; RD3 = i.rdat[2];
    RD = i.rd; ctrl = i.ctrl; imm = i.imm; stall = i.stall; flush = i.flush;
    wb_en = i.wb_en; wb_addr = i.wb_addr; wb_data = i.wb_data;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, ~i.stall});
    model = next_state(model, i);
    sb_q.push_back(model);
    @(posedge clk);
  endtask

  function automatic in_t idle();
    in_t i = '0;
    return i;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.rst      = ($urandom_range(0, 99) < 3);
    i.in_valid = ($urandom_range(0, 99) < 75);
    for (int k = 0; k < 3; k++) begin
      i.rs[k]   = AW'($urandom_range(0, 15));
      i.rdat[k] = $urandom;
    end
    i.rd      = AW'($urandom_range(0, 15));
    i.ctrl    = CW'($urandom);
    i.imm     = $urandom;
    i.stall   = ($urandom_range(0, 99) < 30);
    i.flush   = ($urandom_range(0, 99) < 10);
    i.wb_en   = ($urandom_range(0, 1) == 1);
    i.wb_addr = ($urandom_range(0, 1) == 1) ? i.rs[$urandom_range(0, 2)] : AW'($urandom_range(0, 15));
    i.wb_data = $urandom;
    return i;
  endfunction

  // Monitor: every edge the DUT presents a new stage state; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
        check("ex_op1", {32'd0, ex_op1}, {32'd0, e.op[0]});
        check("ex_op2", {32'd0, ex_op2}, {32'd0, e.op[1]});
        check("ex_op3", {32'd0, ex_op3}, {32'd0, e.op[2]});
        check("ex_rs",  {52'd0, ex_rs3, ex_rs2, ex_rs1}, {52'd0, e.rs[2], e.rs[1], e.rs[0]});
        check("ex_rd",  {60'd0, ex_rd}, {60'd0, e.rd});
        check("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
        check("ex_imm", {32'd0, ex_imm}, {32'd0, e.imm});
        check("stall_count", {48'd0, stall_count}, {32'd0, e.sc});
        check("bubble_count", {48'd0, bubble_count}, {32'd0, e.bc});
      end
    end
  end

  initial begin
    in_t i;
    int unsigned sc0, bc0;
    model = '0;
    {rst, in_valid, stall, flush, wb_en} = '0;
    {RS1, RS2, RS3, RD, wb_addr} = '0;
    {RD1, RD2, RD3, imm, wb_data} = '0;
    ctrl = '0;

    // Reset with busy inputs, then first capture.
    i = rand_in(); i.rst = 1'b1; i.stall = 1'b0; i.flush = 1'b0; i.in_valid = 1'b1;
    drive(i); drive(i);
    #1;
    check("rst_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_op1", {32'd0, ex_op1}, 64'd0);
    i = idle(); i.in_valid = 1'b1; i.rs[0] = 4'd3; i.rdat[0] = 32'd99; i.ctrl = 8'h05;
    drive(i);
    #1;
    check("first_op1", {32'd0, ex_op1}, 64'd99);
    check("first_ctrl", {56'd0, ex_ctrl}, 64'h05);

    // Capture bypass, on and off.
    i = idle(); i.in_valid = 1'b1; i.rs[0] = 4'd5; i.wb_en = 1'b1; i.wb_addr = 4'd5; i.wb_data = 32'd255;
    drive(i);
    #1 check("cap_byp", {32'd0, ex_op1}, 64'd255);
    i.wb_en = 1'b0;
    drive(i);
    #1 check("cap_nobyp", {32'd0, ex_op1}, 64'd0);

    // All three operands bypassed from one write.
    i = idle(); i.in_valid = 1'b1; i.rs = {4'd3, 4'd3, 4'd3}; i.rdat = {32'd7, 32'd7, 32'd7};
    i.wb_en = 1'b1; i.wb_addr = 4'd3; i.wb_data = 32'd2;
    drive(i);
    #1 check("multi_byp", {32'd0, ex_op3, ex_op2}, {32'd0, 32'd2, 32'd2});

    // Stall with a writeback to a held source on the 2nd stalled edge.
    i = idle(); i.in_valid = 1'b1; i.rs[1] = 4'd4; i.rdat[1] = 32'd10; i.ctrl = 8'h3C;
    drive(i);
    sc0 = model.sc;
    i.stall = 1'b1; i.rdat[1] = 32'd77;
    drive(i);
    #1 check("stall_hold_op2", {32'd0, ex_op2}, 64'd10);
    i.wb_en = 1'b1; i.wb_addr = 4'd4; i.wb_data = 32'd50;
    drive(i);
    i.wb_en = 1'b0;
    drive(i);
    #1 check("stall_byp_op2", {32'd0, ex_op2}, 64'd50);
    check("stall_ctrl", {56'd0, ex_ctrl}, 64'h3C);
    check("stall_cnt3", {48'd0, stall_count}, PERF ? 64'(sc0 + 3) : 64'd0);

    // Flush over stall.
    sc0 = model.sc; bc0 = model.bc;
    i.flush = 1'b1;
    drive(i);
    #1 check("flush_valid", {63'd0, ex_valid}, 64'd0);
    check("flush_sc", {48'd0, stall_count}, PERF ? 64'(sc0) : 64'd0);
    check("flush_bc", {48'd0, bubble_count}, PERF ? 64'(bc0 + 1) : 64'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) drive(rand_in());

    // Long stall: saturation when counters are built, constant 0 otherwise.
    i = idle(); i.rst = 1'b1;
    drive(i);
    i = idle(); i.stall = 1'b1;
    for (int n = 0; n < (PERF ? 65540 : 200); n++) drive(i);
    #1 check("stall_sat", {48'd0, stall_count}, PERF ? 64'hFFFF : 64'd0);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL drain actual=%0d required=0", sb_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
